// File: rtl/uart1rx.sv
// 8N1 UART receiver with sticky interrupt, framing-error and overrun flags.
// Optional macro UART1RX_MAJORITY_EN selects 2-of-3 majority sampling around each bit centre.
module uart1rx #(
  parameter int CLOCK_DIV          = 10,
  parameter int CLOCK_COUNTER_BITS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       interrupt,
  input  logic       interrupt_clear,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  localparam logic [CLOCK_COUNTER_BITS-1:0] RELOAD = CLOCK_COUNTER_BITS'(CLOCK_DIV - 1);
  localparam logic [CLOCK_COUNTER_BITS-1:0] HALF   = CLOCK_COUNTER_BITS'(CLOCK_DIV / 2 - 1);

  state_t                        state_q, state_d;
  logic [CLOCK_COUNTER_BITS-1:0] cnt_q, cnt_d;
  logic [2:0]                    idx_q, idx_d;
  logic [7:0]                    sh_q, sh_d;
  logic [7:0]                    data_q, data_d;
  logic                          int_q, int_d;
  logic                          fe_q, fe_d;
  logic                          ovr_q, ovr_d;
  logic                          sync1_q, sync2_q, prev_q;
  logic                          rxs, fall, cnt_tick, fire, bit_val, int_set, fe_set;

  assign rxs      = sync2_q;
  assign fall     = prev_q & ~rxs;
  assign cnt_tick = (state_q != IDLE) && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

`ifdef UART1RX_MAJORITY_EN
  // Votes on counter=1 and counter=0 samples plus the live sample one clk after reload.
  logic v1_q, v0_q, pend_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q   <= 1'b1;
      v0_q   <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      if ((state_q != IDLE) && (cnt_q == CLOCK_COUNTER_BITS'(1))) v1_q <= rxs;
      if (cnt_tick) v0_q <= rxs;
      pend_q <= cnt_tick;
    end
  end

  assign fire    = pend_q && (state_q != IDLE);
  assign bit_val = (v1_q & v0_q) | (v1_q & rxs) | (v0_q & rxs);
`else
  assign fire    = cnt_tick;
  assign bit_val = rxs;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    int_set = 1'b0;
    fe_set  = 1'b0;
    if (state_q != IDLE) cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
    case (state_q)
      IDLE: begin
        if (fall) begin
          cnt_d   = HALF;
          state_d = START;
        end
      end
      START: begin
        if (fire) begin
          if (bit_val) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = 3'd0;
          end
        end
      end
      DATA: begin
        if (fire) begin
          sh_d  = {bit_val, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (fire) begin
          if (bit_val) begin
            data_d  = sh_q;
            int_set = 1'b1;
            state_d = IDLE;
          end else begin
            fe_set  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A flag being set in the same clk as interrupt_clear stays set.
    int_d = int_set | (int_q & ~interrupt_clear);
    ovr_d = (int_set & int_q) | (ovr_q & ~interrupt_clear);
    fe_d  = fe_set | (fe_q & ~interrupt_clear);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      sh_q    <= 8'd0;
      data_q  <= 8'd0;
      int_q   <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      int_q   <= int_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data          = data_q;
  assign interrupt     = int_q;
  assign framing_error = fe_q;
  assign overrun       = ovr_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart1rx.sv
// Bench for uart1rx: table of directed frames, hand-written corner cases, then random frames
// checked against a frame-level flag model.
module tb_uart1rx;
  localparam int CD = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       interrupt_clear = 1'b0;
  logic [7:0] data;
  logic       interrupt, framing_error, overrun, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart1rx #(.CLOCK_DIV(CD), .CLOCK_COUNTER_BITS(4)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data(data), .interrupt(interrupt),
    .interrupt_clear(interrupt_clear), .framing_error(framing_error),
    .overrun(overrun), .busy(busy)
  );

  // Frame-level reference: good frame latches byte and sets interrupt (overrun if already set).
  logic [7:0] m_data = 8'd0;
  bit m_int = 0, m_fe = 0, m_ovr = 0;

  int frame_cyc, rise_cyc;
  bit int_watch;

  typedef struct {
    bit         clr;
    logic [7:0] b;
    int         stop_low;
    logic [7:0] e_data;
    bit         e_int, e_fe, e_ovr;
  } vec_t;
  vec_t vt[6];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    for (int i = 0; i < n; i++) begin
      tick();
      frame_cyc++;
      if (int_watch && interrupt && rise_cyc < 0) rise_cyc = frame_cyc;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low, input int glitch_bit);
    frame_cyc = 0;
    rise_cyc  = -1;
    int_watch = !interrupt;
    hold(1'b0, CD);
    for (int k = 0; k < 8; k++) begin
      if (k == glitch_bit) begin
        hold(b[k], 5);
        hold(~b[k], 1);
        hold(b[k], CD - 6);
      end else begin
        hold(b[k], CD);
      end
    end
    if (stop_low > 0) begin
      hold(1'b0, stop_low);
      chk("busy_while_break", busy, 1);
    end
    hold(1'b1, CD);
    if (stop_low == 0 && int_watch)
      chk("int_latency_97_99", (rise_cyc >= 97 && rise_cyc <= 99) ? 1 : 0, 1);
    $display("frame %02h stop_low=%0d glitch=%0d -> data=%02h int=%0b fe=%0b ovr=%0b busy=%0b",
             b, stop_low, glitch_bit, data, interrupt, framing_error, overrun, busy);
  endtask

  task automatic model_frame(input logic [7:0] b, input int stop_low);
    if (stop_low == 0) begin
      m_ovr  = m_ovr | m_int;
      m_int  = 1;
      m_data = b;
    end else begin
      m_fe = 1;
    end
  endtask

  task automatic pulse_clear();
    interrupt_clear = 1'b1;
    tick();
    interrupt_clear = 1'b0;
    m_int = 0; m_fe = 0; m_ovr = 0;
    chk("clear_int", interrupt, 0);
    chk("clear_fe", framing_error, 0);
    chk("clear_ovr", overrun, 0);
    $display("clear -> int=%0b fe=%0b ovr=%0b", interrupt, framing_error, overrun);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_data"}, data, m_data);
    chk({tag, "_int"}, interrupt, m_int);
    chk({tag, "_fe"}, framing_error, m_fe);
    chk({tag, "_ovr"}, overrun, m_ovr);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen_busy;
    int n;
    logic [7:0] b;
    int sl;

    vt[0] = '{0, 8'h5A, 0,  8'h5A, 1, 0, 0};
    vt[1] = '{1, 8'hA5, 0,  8'hA5, 1, 0, 0};
    vt[2] = '{1, 8'h11, 0,  8'h11, 1, 0, 0};
    vt[3] = '{0, 8'h22, 0,  8'h22, 1, 0, 1};
    vt[4] = '{0, 8'h3C, 30, 8'h22, 1, 1, 1};
    vt[5] = '{1, 8'h3C, 0,  8'h3C, 1, 0, 0};

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_data", data, 0);
    chk("reset_int", interrupt, 0);
    chk("reset_fe", framing_error, 0);
    chk("reset_ovr", overrun, 0);
    chk("reset_busy", busy, 0);

    for (int i = 0; i < 6; i++) begin
      if (vt[i].clr) pulse_clear();
      send_frame(vt[i].b, vt[i].stop_low, -1);
      model_frame(vt[i].b, vt[i].stop_low);
      chk($sformatf("vec%0d_data", i), data, vt[i].e_data);
      chk($sformatf("vec%0d_int", i), interrupt, vt[i].e_int);
      chk($sformatf("vec%0d_fe", i), framing_error, vt[i].e_fe);
      chk($sformatf("vec%0d_ovr", i), overrun, vt[i].e_ovr);
      chk($sformatf("vec%0d_busy", i), busy, 0);
    end

    // False start: 3-clk low pulse.
    seen_busy = 0;
    rx = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy) seen_busy = 1;
    end
    rx = 1'b1;
    n = 0;
    while (n < CD / 2 + 3) begin
      tick();
      n++;
      if (busy) seen_busy = 1;
      else if (seen_busy) break;
    end
    chk("false_start_busy_seen", seen_busy, 1);
    chk("false_start_busy_low", busy, 0);
    check_model("false_start");
    $display("false start pulse -> busy low after %0d clks", n);

`ifdef UART1RX_MAJORITY_EN
    send_frame(8'hFF, 0, 3);
    model_frame(8'hFF, 0);
    check_model("glitch_ff");
`endif

    // Reset in the middle of DATA discards the frame and clears everything.
    frame_cyc = 0; rise_cyc = -1; int_watch = 0;
    hold(1'b0, CD);
    hold(1'b1, CD);
    hold(1'b1, CD);
    hold(1'b0, 5);
    reset = 1'b1;
    rx = 1'b1;
    tick();
    reset = 1'b0;
    m_data = 8'd0; m_int = 0; m_fe = 0; m_ovr = 0;
    chk("midreset_data", data, 0);
    chk("midreset_int", interrupt, 0);
    chk("midreset_fe", framing_error, 0);
    chk("midreset_ovr", overrun, 0);
    chk("midreset_busy", busy, 0);
    $display("reset mid frame -> data=%02h int=%0b busy=%0b", data, interrupt, busy);
    hold(1'b1, 2 * CD);
    send_frame(8'h81, 0, -1);
    model_frame(8'h81, 0);
    check_model("after_reset_81");

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(1, 0) == 1) pulse_clear();
      b  = 8'($urandom);
      sl = ($urandom_range(4, 0) == 0) ? int'($urandom_range(40, 15)) : 0;
      send_frame(b, sl, -1);
      model_frame(b, sl);
      check_model($sformatf("rand%0d", i));
      hold(1'b1, int'($urandom_range(3, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
